// File: rtl/count113.sv
// Loadable 8-bit up-counter divider: counts load..255 then reloads, toggling
// tff_out and bumping the duration counter on every wrap.
module count113 (
   input  logic       clk,
   input  logic       JKreset,
   input  logic       preset,
   input  logic       rst,
   input  logic       input0,
   input  logic       input1,
   input  logic       input2,
   input  logic       input3,
   input  logic       input4,
   input  logic       input5,
   input  logic       input6,
   input  logic       input7,
   output logic       output0,
   output logic       output1,
   output logic       output2,
   output logic       output3,
   output logic       output4,
   output logic       output5,
   output logic       output6,
   output logic       output7,
   output logic       tff_out,
   output logic [7:0] duration
);

   logic [7:0] load_val;
   logic [7:0] cnt_q;
   logic [7:0] cnt_d;
   logic       tff_q;
   logic       tff_d;
   logic [7:0] dur_q;
   logic [7:0] dur_d;
   logic       at_top;
   logic       wrap;

   assign load_val = {input7, input6, input5, input4,
                      input3, input2, input1, input0};

   // A parallel load preempts the terminal count, so it never counts as a wrap.
   assign at_top = (cnt_q == 8'hFF);
   assign wrap   = preset && at_top;

   always_comb begin
      cnt_d = cnt_q;
      tff_d = tff_q;
      dur_d = dur_q;

      if (!preset) begin
         cnt_d = load_val;
      end else if (at_top) begin
         cnt_d = load_val;
      end else begin
         cnt_d = cnt_q + 8'd1;
      end

      if (wrap) begin
         tff_d = ~tff_q;
      end

      // Clear wins over a simultaneous wrap increment.
      if (rst) begin
         dur_d = 8'd0;
      end else if (wrap) begin
         dur_d = dur_q + 8'd1;
      end
   end

   always_ff @(posedge clk or negedge JKreset) begin
      if (!JKreset) begin
         cnt_q <= 8'd0;
         tff_q <= 1'b0;
         dur_q <= 8'd0;
      end else begin
         cnt_q <= cnt_d;
         tff_q <= tff_d;
         dur_q <= dur_d;
      end
   end

   assign output0  = cnt_q[0];
   assign output1  = cnt_q[1];
   assign output2  = cnt_q[2];
   assign output3  = cnt_q[3];
   assign output4  = cnt_q[4];
   assign output5  = cnt_q[5];
   assign output6  = cnt_q[6];
   assign output7  = cnt_q[7];
   assign tff_out  = tff_q;
   assign duration = dur_q;

endmodule

// File: tb/tb_count113.sv
// Directed bench for count113: reset, load, wrap period, duration clear and
// priority cases, checked with immediate assertions.
module tb_count113;

   logic       clk;
   logic       JKreset;
   logic       preset;
   logic       rst;
   logic [7:0] in_val;
   logic       o0, o1, o2, o3, o4, o5, o6, o7;
   logic       tff_out;
   logic [7:0] duration;
   logic [7:0] cnt;

   int checks   = 0;
   int failures = 0;

   count113 dut (
      .clk      (clk),
      .JKreset  (JKreset),
      .preset   (preset),
      .rst      (rst),
      .input0   (in_val[0]),
      .input1   (in_val[1]),
      .input2   (in_val[2]),
      .input3   (in_val[3]),
      .input4   (in_val[4]),
      .input5   (in_val[5]),
      .input6   (in_val[6]),
      .input7   (in_val[7]),
      .output0  (o0),
      .output1  (o1),
      .output2  (o2),
      .output3  (o3),
      .output4  (o4),
      .output5  (o5),
      .output6  (o6),
      .output7  (o7),
      .tff_out  (tff_out),
      .duration (duration)
   );

   assign cnt = {o7, o6, o5, o4, o3, o2, o1, o0};

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic tick(input int n);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   task automatic check_all(input string tag, input logic [7:0] c,
                            input logic t, input logic [7:0] d);
      check({tag, ".cnt"}, cnt, c);
      check({tag, ".tff"}, {7'd0, tff_out}, {7'd0, t});
      check({tag, ".dur"}, duration, d);
   endtask

   initial begin
      JKreset = 1'b0;
      preset  = 1'b1;
      rst     = 1'b0;
      in_val  = 8'd142;

      // Asynchronous reset, before the first clock edge
      #3;
      check_all("rst_noclk", 8'd0, 1'b0, 8'd0);
      tick(3);
      check_all("rst_held", 8'd0, 1'b0, 8'd0);

      // Release reset and parallel load 142
      JKreset = 1'b1;
      preset  = 1'b0;
      tick(1);
      check_all("load", 8'd142, 1'b0, 8'd0);
      tick(10);
      check_all("load_hold", 8'd142, 1'b0, 8'd0);

      // Count to the terminal value and wrap twice (114-clock period)
      preset = 1'b1;
      tick(113);
      check_all("top1", 8'd255, 1'b0, 8'd0);
      tick(1);
      check_all("wrap1", 8'd142, 1'b1, 8'd1);
      tick(114);
      check_all("wrap2", 8'd142, 1'b0, 8'd2);

      // 256 further wraps: duration returns to 2, tff back to 0
      tick(256 * 114);
      check_all("wrap256", 8'd142, 1'b0, 8'd2);

      // Reach duration 5, then a one-edge clear mid-count
      tick(3 * 114);
      check_all("dur5", 8'd142, 1'b1, 8'd5);
      tick(10);
      check("pre_clr.cnt", cnt, 8'd152);
      rst = 1'b1;
      tick(1);
      rst = 1'b0;
      check_all("clr_mid", 8'd153, 1'b1, 8'd0);

      // Clear coinciding with a wrap edge: clear wins, tff still toggles
      tick(102);
      check_all("top_clr", 8'd255, 1'b1, 8'd0);
      rst = 1'b1;
      tick(1);
      rst = 1'b0;
      check_all("clr_wrap", 8'd142, 1'b0, 8'd0);

      // Load at terminal count takes priority and is not a wrap
      tick(113);
      check_all("top2", 8'd255, 1'b0, 8'd0);
      preset = 1'b0;
      in_val = 8'd200;
      tick(1);
      check_all("load_at_top", 8'd200, 1'b0, 8'd0);

      // Load value 255: wrap on every clock
      in_val = 8'd255;
      tick(1);
      check_all("load255", 8'd255, 1'b0, 8'd0);
      preset = 1'b1;
      tick(1);
      check_all("l255_w1", 8'd255, 1'b1, 8'd1);
      tick(1);
      check_all("l255_w2", 8'd255, 1'b0, 8'd2);
      tick(1);
      check_all("l255_w3", 8'd255, 1'b1, 8'd3);

      // Mid-count asynchronous reset at 180
      preset = 1'b0;
      in_val = 8'd142;
      tick(1);
      preset = 1'b1;
      tick(38);
      check_all("at180", 8'd180, 1'b1, 8'd3);
      #3;
      JKreset = 1'b0;
      #1;
      check_all("async_mid", 8'd0, 1'b0, 8'd0);
      #2;
      JKreset = 1'b1;
      #1;
      check_all("release", 8'd0, 1'b0, 8'd0);
      tick(1);
      check("resume1.cnt", cnt, 8'd1);
      tick(1);
      check("resume2.cnt", cnt, 8'd2);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
